// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts out an up-to-8-bit pattern MSB-first, one bit per
// TICK_DIV clocks, with optional repeat separated by GAP_BITS idle bit periods.
module seq_pattern_tx #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] pattern,
  input  logic [3:0] len,
  input  logic       repeat_en,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned PAT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    GAP    = 2'b10,
    FINISH = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bit_end;
  logic [LEN_W-1:0]   len_eff;
  logic [IDX_W-1:0]   new_top;
  logic [IDX_W-1:0]   latched_top;

  assign bit_end     = (cnt_q == CNT_MAX);
  assign len_eff     = (len > LEN_W'(8)) ? LEN_W'(8) : len;
  assign new_top     = IDX_W'(len_eff - LEN_W'(1));
  assign latched_top = IDX_W'(len_q - LEN_W'(1));

  // Next-state and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop && (len != LEN_W'(0))) begin
          pat_d   = pattern;
          len_d   = len_eff;
          idx_d   = new_top;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = SHIFT;
          out_d   = pattern[new_top];
          valid_d = 1'b1;
        end
      end
      SHIFT: begin
        out_d   = out_q;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(0)) begin
            out_d   = 1'b0;
            valid_d = 1'b0;
            gap_d   = '0;
            state_d = repeat_en ? GAP : FINISH;
            done_d  = !repeat_en;
          end else begin
            idx_d = idx_q - IDX_W'(1);
            out_d = pat_q[idx_q - IDX_W'(1)];
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (gap_q == GAP_MAX) begin
            state_d = SHIFT;
            idx_d   = latched_top;
            out_d   = pat_q[latched_top];
            valid_d = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE and suppresses done
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      out_d   = 1'b0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      gap_d   = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a queue-based waveform model expands each transmission into
// per-cycle expected outputs; every cycle is compared, plus literal anchor points.
module tb_seq_pattern_tx;

  localparam int TICK = 4;
  localparam int GAPB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] len = 4'd0;
  logic       repeat_en = 1'b0;
  logic       out, valid, busy, done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(.TICK_DIV(TICK), .GAP_BITS(GAPB)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pattern(pattern),
    .len(len), .repeat_en(repeat_en), .out(out), .valid(valid), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       o;
    logic       v;
    logic [1:0] st;
  } ent_t;

  ent_t mq[$];
  ent_t cur = '0;
  logic [7:0] m_pat = 8'h00;
  int         m_len = 0;

  function automatic ent_t mk(logic o, logic v, logic [1:0] st);
    ent_t e;
    e.o = o; e.v = v; e.st = st;
    return e;
  endfunction

  task automatic push_pattern();
    for (int i = m_len - 1; i >= 0; i--)
      for (int k = 0; k < TICK; k++) mq.push_back(mk(m_pat[i], 1'b1, 2'b01));
  endtask

  // Model advances on every clock edge (or reset edge)
  task automatic model_step();
    if (rst) begin
      mq.delete(); cur = '0; m_pat = 8'h00; m_len = 0;
      return;
    end
    if (cur.st != 2'b00 && stop) begin
      mq.delete(); cur = '0;
      return;
    end
    if (cur.st == 2'b00) begin
      if (start && !stop && len != 4'd0) begin
        m_pat = pattern;
        m_len = (len > 4'd8) ? 8 : int'(len);
        push_pattern();
      end
    end else if (mq.size() == 0 && cur.st == 2'b01) begin
      if (repeat_en) begin
        for (int k = 0; k < GAPB * TICK; k++) mq.push_back(mk(1'b0, 1'b0, 2'b10));
        push_pattern();
      end else begin
        mq.push_back(mk(1'b0, 1'b0, 2'b11));
      end
    end
    cur = (mq.size() != 0) ? mq.pop_front() : ent_t'('0);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  function automatic logic [5:0] dut_vec();
    return {out, valid, busy, done, state};
  endfunction

  function automatic logic [5:0] mdl_vec();
    return {cur.o, cur.v, cur.st != 2'b00, cur.st == 2'b11, cur.st};
  endfunction

  // Every-cycle comparison of DUT against the model
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dut=%b expected=%b", $time, dut_vec(), mdl_vec());
      end
    end
  end

  // Literal anchors applied to both DUT and model
  task automatic lit(input string name, input logic [5:0] want);
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL %s dut=%b expected=%b", name, dut_vec(), want);
    end
    checks++;
    if (mdl_vec() !== want) begin
      errors++;
      $display("FAIL %s_model model=%b expected=%b", name, mdl_vec(), want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    lit("reset_state", 6'b000000);
    rst = 1'b0;
    cyc(2);

    // pattern 101, no repeat
    pattern = 8'b0000_0101; len = 4'd3; repeat_en = 1'b0; start = 1'b1;
    cyc(1); start = 1'b0;
    lit("p101_bit2", 6'b111001);
    cyc(4); lit("p101_bit1", 6'b011001);
    pattern = 8'hFF;
    cyc(4); lit("p101_bit0", 6'b111001);
    cyc(4); lit("p101_done", 6'b001111);
    cyc(1); lit("p101_idle", 6'b000000);
    cyc(3);

    // pattern 101 with repeat, then abort
    pattern = 8'b0000_0101; len = 4'd3; repeat_en = 1'b1; start = 1'b1;
    cyc(1); start = 1'b0; pattern = 8'hFF;
    cyc(12); lit("rep_gap", 6'b001010);
    cyc(4); lit("rep_restart", 6'b111001);
    cyc(4); lit("rep_bit1", 6'b011001);
    cyc(20);
    stop = 1'b1;
    cyc(1); stop = 1'b0;
    lit("rep_stopped", 6'b000000);
    repeat_en = 1'b0;
    cyc(3);

    // len=0 ignored; stop beats start in IDLE
    len = 4'd0; pattern = 8'hFF; start = 1'b1;
    cyc(1); lit("len0_ignored", 6'b000000);
    len = 4'd3; stop = 1'b1;
    cyc(1); lit("stop_wins", 6'b000000);
    start = 1'b0; stop = 1'b0;
    cyc(2);

    // len clamp to 8 with A5
    pattern = 8'hA5; len = 4'd12; start = 1'b1;
    cyc(1); start = 1'b0;
    lit("a5_b7", 6'b111001);
    cyc(4); lit("a5_b6", 6'b011001);
    cyc(12); lit("a5_b3", 6'b011001);
    cyc(4); lit("a5_b2", 6'b111001);
    cyc(12); lit("a5_done", 6'b001111);
    cyc(3);

    // stop on clk 6 of a len=3 transmission
    pattern = 8'b0000_0101; len = 4'd3; start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(4); stop = 1'b1;
    cyc(1); stop = 1'b0;
    lit("stop_clk6", 6'b000000);
    cyc(15);

    // start held high: IDLE lasts exactly one clock between transmissions
    pattern = 8'h01; len = 4'd1; start = 1'b1;
    cyc(5); lit("held_finish", 6'b001111);
    cyc(1); lit("held_idle", 6'b000000);
    cyc(1); lit("held_restart", 6'b111001);
    start = 1'b0;
    cyc(2);

    // asynchronous reset mid-bit
    @(posedge clk); #1 rst = 1'b1;
    #1 lit("rst_async", 6'b000000);
    cyc(2); rst = 1'b0;
    cyc(2);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0) || (n % 500 > 420);
      stop      = ($urandom_range(0, 59) == 0);
      pattern   = 8'($urandom);
      len       = 4'($urandom_range(0, 15));
      repeat_en = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
